// File: rtl/clk_div_ctrl_pkg.sv
// rtl/clk_div_ctrl_pkg.sv - shared types and helpers for the clock-divide controller
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } div_state_t;

    // A half-period of zero has no meaning; treat it as the fastest legal rate.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - control, config handshake and divided-output bundle
interface clk_div_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             div_out;
    logic             tick;
    logic             running;
    logic [WIDTH-1:0] cur_div;

    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, div_out, tick, running, cur_div
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, div_out, tick, running, cur_div
    );
endinterface

// File: rtl/clk_div_ctrl_phase_core.sv
// rtl/clk_div_ctrl_phase_core.sv - phase counter producing the divided level and toggle tick
module div_phase_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_n,
    input  logic [WIDTH-1:0] n,
    output logic             div_out,
    output logic             tick,
    output logic             wrap_next
);
    logic [WIDTH-1:0] cnt;

    // Compare one bit wider so cnt+1 can never alias back onto a small n.
    assign wrap_next = (({1'b0, cnt} + (WIDTH+1)'(1)) == {1'b0, n});

    // Count through one phase; toggle and pulse tick on the last cycle of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            div_out <= 1'b0;
            tick    <= 1'b0;
        end else if (wrap_next) begin
            cnt     <= '0;
            div_out <= ~div_out;
            tick    <= 1'b1;
        end else begin
            tick    <= 1'b0;
            cnt     <= load_n ? '0 : cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - start/stop FSM and boundary-safe half-period update for the divider
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEF_N = 5
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_PEND = PEND;
    localparam logic [1:0] S_STOP = STOP;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] cur_div, cur_nx;
    logic [WIDTH-1:0] pend_div, pend_nx;
    logic             pend_flag, pflag_nx;
    logic             cfg_ready_r, running_r;
    logic             core_en, core_load;
    logic             core_div, core_tick, wrap_next;
    logic             cfg_fire;
    logic [WIDTH-1:0] cfg_clamped;

    assign cfg_fire    = bus.cfg_valid && cfg_ready_r;
    assign cfg_clamped = WIDTH'(clamp_div(32'(bus.cfg_div)));

    div_phase_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (core_en),
        .load_n    (core_load),
        .n         (cur_div),
        .div_out   (core_div),
        .tick      (core_tick),
        .wrap_next (wrap_next)
    );

    // Next-state, counter enable and half-period bookkeeping.
    always_comb begin
        state_nx  = state;
        cur_nx    = cur_div;
        pend_nx   = pend_div;
        pflag_nx  = pend_flag;
        core_en   = (state != S_IDLE);
        core_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_fire)
                    cur_nx = cfg_clamped;
                if (bus.start && !bus.stop)
                    state_nx = S_RUN;
            end
            S_RUN, S_PEND: begin
                if (state == S_RUN && cfg_fire) begin
                    pend_nx  = cfg_clamped;
                    pflag_nx = 1'b1;
                end
                if (bus.stop) begin
                    // Low level: quit now without a tick. High level ending this
                    // edge: the fall is the last toggle. Otherwise finish the phase.
                    if (!core_div) begin
                        core_en  = 1'b0;
                        state_nx = S_IDLE;
                    end else if (wrap_next) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_STOP;
                    end
                end else if (state == S_RUN) begin
                    if (cfg_fire)
                        state_nx = S_PEND;
                end else if (wrap_next) begin
                    cur_nx    = pend_div;
                    pflag_nx  = 1'b0;
                    core_load = 1'b1;
                    state_nx  = S_RUN;
                end
            end
            S_STOP: begin
                if (wrap_next)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Any value still pending takes effect on the edge that reaches IDLE.
        if (state != S_IDLE && state_nx == S_IDLE && pflag_nx) begin
            cur_nx   = pend_nx;
            pflag_nx = 1'b0;
        end
    end

    // Controller registers, including the registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_div     <= WIDTH'(DEF_N);
            pend_div    <= '0;
            pend_flag   <= 1'b0;
            cfg_ready_r <= 1'b1;
            running_r   <= 1'b0;
        end else begin
            state       <= state_nx;
            cur_div     <= cur_nx;
            pend_div    <= pend_nx;
            pend_flag   <= pflag_nx;
            cfg_ready_r <= (state_nx == S_IDLE) || (state_nx == S_RUN);
            running_r   <= (state_nx != S_IDLE);
        end
    end

    assign bus.cfg_ready = cfg_ready_r;
    assign bus.running   = running_r;
    assign bus.cur_div   = cur_div;
    assign bus.div_out   = core_div;
    assign bus.tick      = core_tick;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed scoreboard bench for clk_div_ctrl
module tb_clk_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t;
    int   cnt_ticks;

    typedef struct {
        int   cyc;
        logic lvl;
    } tick_exp_t;

    tick_exp_t exp_q[$];

    clk_div_ctrl_if #(.WIDTH(4)) bus ();

    clk_div_ctrl #(.WIDTH(4), .DEF_N(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_tick(input int c, input logic l);
        tick_exp_t e;
        e.cyc = c;
        e.lvl = l;
        exp_q.push_back(e);
    endtask

    task automatic chk_tick(input string tag);
        tick_exp_t e;
        int   got;
        logic lvl;
        e   = exp_q.pop_front();
        got = -1;
        lvl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) begin
                got = cyc;
                lvl = bus.div_out;
                break;
            end
        end
        check({tag, "_cyc"}, got, e.cyc);
        check({tag, "_lvl"}, 32'(lvl), 32'(e.lvl));
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_div_out", 32'(bus.div_out), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_running", 32'(bus.running), 0);
        check("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        check("rst_cur_div", 32'(bus.cur_div), 5);

        // Default divide of 5
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 6, 1'b1);
        push_tick(t + 11, 1'b0);
        push_tick(t + 16, 1'b1);
        push_tick(t + 21, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("run_running", 32'(bus.running), 1);
        for (int i = 0; i < 4; i++) chk_tick("def5");
        check("def5_cur_div", 32'(bus.cur_div), 5);

        // New half-period offered mid-phase, applied at the boundary
        t = cyc;
        repeat (2) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd3;
        push_tick(t + 5, 1'b1);
        push_tick(t + 8, 1'b0);
        push_tick(t + 11, 1'b1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("pend_cfg_ready", 32'(bus.cfg_ready), 0);
        check("pend_cur_div", 32'(bus.cur_div), 5);
        chk_tick("swap_first");
        check("swap_cur_div", 32'(bus.cur_div), 3);
        check("swap_cfg_ready", 32'(bus.cfg_ready), 1);
        chk_tick("n3_a");
        chk_tick("n3_b");

        // Graceful stop from the high phase
        t = cyc;
        bus.stop = 1'b1;
        push_tick(t + 3, 1'b0);
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_hi_running", 32'(bus.running), 1);
        check("stop_hi_cfg_ready", 32'(bus.cfg_ready), 0);
        chk_tick("stop_hi_fall");
        check("stop_hi_idle", 32'(bus.running), 0);
        check("stop_hi_cfg_ready1", 32'(bus.cfg_ready), 1);

        // Immediate stop from the low phase
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 4, 1'b1);
        push_tick(t + 7, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk_tick("lo_a");
        chk_tick("lo_b");
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_lo_running", 32'(bus.running), 0);
        check("stop_lo_tick", 32'(bus.tick), 0);
        check("stop_lo_div_out", 32'(bus.div_out), 0);
        cnt_ticks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tick === 1'b1) cnt_ticks++;
        end
        check("idle_no_ticks", cnt_ticks, 0);

        // Zero clamps to one: toggle every cycle
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd0;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("clamp_cur_div", 32'(bus.cur_div), 1);
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 2, 1'b1);
        push_tick(t + 3, 1'b0);
        push_tick(t + 4, 1'b1);
        push_tick(t + 5, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) chk_tick("n1");
        cnt_ticks = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.tick === 1'b1) cnt_ticks++;
        end
        check("n1_tick_const", cnt_ticks, 3);
        bus.stop = 1'b1;
        repeat (2) @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
        check("n1_stop_running", 32'(bus.running), 0);
        check("n1_stop_div_out", 32'(bus.div_out), 0);

        // Maximum half-period
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd15;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("max_cur_div", 32'(bus.cur_div), 15);
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 16, 1'b1);
        push_tick(t + 31, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk_tick("n15_a");
        chk_tick("n15_b");
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("n15_stop_running", 32'(bus.running), 0);

        // cfg and stop in the same RUN cycle
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 16, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk_tick("both_a");
        @(negedge clk);
        check("both_cfg_ready", 32'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd7;
        bus.stop      = 1'b1;
        push_tick(t + 31, 1'b0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        bus.stop      = 1'b0;
        check("both_running", 32'(bus.running), 1);
        check("both_cur_div_hold", 32'(bus.cur_div), 15);
        chk_tick("both_fall");
        check("both_idle", 32'(bus.running), 0);
        check("both_cur_div", 32'(bus.cur_div), 7);
        check("both_cfg_ready1", 32'(bus.cfg_ready), 1);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        repeat (2) @(negedge clk);
        check("ss_running", 32'(bus.running), 0);
        check("ss_div_out", 32'(bus.div_out), 0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Asynchronous reset while a new value is pending
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 8, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk_tick("pre_rst");
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 4'd2;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        check("pre_rst_pend", 32'(bus.cfg_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_div_out", 32'(bus.div_out), 0);
        check("arst_running", 32'(bus.running), 0);
        check("arst_cfg_ready", 32'(bus.cfg_ready), 1);
        check("arst_cur_div", 32'(bus.cur_div), 5);
        check("arst_tick", 32'(bus.tick), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t = cyc;
        bus.start = 1'b1;
        push_tick(t + 6, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk_tick("post_rst");
        check("post_rst_cur_div", 32'(bus.cur_div), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
